// File: rtl/sw_debouncer_pkg.sv
// rtl/sw_debouncer_pkg.sv - shared state encodings and default parameters for the switch debouncer
package sw_debouncer_pkg;

  // Per-bit debounce FSM states; encodings are fixed so they read the same in waveforms
  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_PEND_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_PEND_LOW    = 2'd3
  } deb_state_t;

  localparam int DEFAULT_NB_COUNTER     = 14;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 10000;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser, debounce FSM, stability counter and edge pulses for one switch
module debounce_bit
  import sw_debouncer_pkg::*;
#(
  parameter int NB_COUNTER     = DEFAULT_NB_COUNTER,
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);

  // Counter value on the last qualifying cycle; counting stops here so it never wraps
  localparam logic [NB_COUNTER-1:0] LIMIT_M1 = NB_COUNTER'(DEBOUNCE_LIMIT - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  deb_state_t            r_state;
  deb_state_t            w_state_nxt;
  logic [NB_COUNTER-1:0] r_count;
  logic [NB_COUNTER-1:0] w_count_nxt;
  logic                  r_sw;
  logic                  r_rise;
  logic                  r_fall;
  logic                  w_sw_nxt;
  logic                  w_rise_nxt;
  logic                  w_fall_nxt;
  logic                  w_s;
  logic                  w_at_limit;

  assign w_s        = r_sync2;
  assign w_at_limit = (r_count == LIMIT_M1);

  // Two-flop synchroniser for the asynchronous switch input
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state <= ST_STABLE_LOW;
      r_count <= '0;
      r_sw    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_sw    <= w_sw_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next state and counter: any opposite sample during a pending state abandons qualification
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_PEND_HIGH;
          w_count_nxt = '0;
        end
      end
      ST_PEND_HIGH: begin
        if (!w_s)            w_state_nxt = ST_STABLE_LOW;
        else if (w_at_limit) w_state_nxt = ST_STABLE_HIGH;
        else                 w_count_nxt = r_count + NB_COUNTER'(1);
      end
      ST_STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_PEND_LOW;
          w_count_nxt = '0;
        end
      end
      ST_PEND_LOW: begin
        if (w_s)             w_state_nxt = ST_STABLE_HIGH;
        else if (w_at_limit) w_state_nxt = ST_STABLE_LOW;
        else                 w_count_nxt = r_count + NB_COUNTER'(1);
      end
      default: w_state_nxt = ST_STABLE_LOW;
    endcase
  end

  // Output decode: level follows the stable side, pulses only on a qualified transition
  always_comb begin
    w_sw_nxt   = (w_state_nxt == ST_STABLE_HIGH) || (w_state_nxt == ST_PEND_LOW);
    w_rise_nxt = (r_state == ST_PEND_HIGH) && (w_state_nxt == ST_STABLE_HIGH);
    w_fall_nxt = (r_state == ST_PEND_LOW) && (w_state_nxt == ST_STABLE_LOW);
  end

  assign o_sw   = r_sw;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - per-switch debouncer array with rise/fall pulse outputs
module sw_debouncer
  import sw_debouncer_pkg::*;
#(
  parameter int NB_SW          = 4,
  parameter int NB_COUNTER     = DEFAULT_NB_COUNTER,
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_sw_rise,
  output logic [NB_SW-1:0] o_sw_fall
);

  // The limit must be reachable by the counter and at least one cycle
  if (DEBOUNCE_LIMIT < 1 || DEBOUNCE_LIMIT > (2**NB_COUNTER) - 1) begin : g_bad_limit
    $error("sw_debouncer: DEBOUNCE_LIMIT out of range for NB_COUNTER");
  end

  // One independent channel per switch
  for (genvar g = 0; g < NB_SW; g++) begin : g_bit
    debounce_bit #(
      .NB_COUNTER     (NB_COUNTER),
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_bit (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw[g]),
      .o_sw    (o_sw[g]),
      .o_rise  (o_sw_rise[g]),
      .o_fall  (o_sw_fall[g])
    );
  end

endmodule

// File: tb/tb_sw_debouncer.sv
// tb/tb_sw_debouncer.sv - table-driven bench for sw_debouncer
module tb_sw_debouncer;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    int         ncyc;
    logic [3:0] e_sw;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
  } vec_t;

  logic       clk = 1'b0;
  logic       tb_reset = 1'b1;
  logic [3:0] tb_sw = 4'h0;
  logic [3:0] w_sw, w_rise, w_fall;
  logic [0:0] tb_sw1 = 1'b0;
  logic [0:0] w1_sw, w1_rise, w1_fall;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  sw_debouncer #(.NB_SW(4), .NB_COUNTER(4), .DEBOUNCE_LIMIT(8)) dut (
    .clock(clk), .i_reset(tb_reset), .i_sw(tb_sw),
    .o_sw(w_sw), .o_sw_rise(w_rise), .o_sw_fall(w_fall)
  );

  sw_debouncer #(.NB_SW(1), .NB_COUNTER(1), .DEBOUNCE_LIMIT(1)) dut1 (
    .clock(clk), .i_reset(tb_reset), .i_sw(tb_sw1),
    .o_sw(w1_sw), .o_sw_rise(w1_rise), .o_sw_fall(w1_fall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] sw, input int n,
                     input logic [3:0] es, input logic [3:0] er, input logic [3:0] ef);
    vec_t v;
    v.rst = rst; v.sw = sw; v.ncyc = n; v.e_sw = es; v.e_rise = er; v.e_fall = ef;
    vq.push_back(v);
  endtask

  task automatic chk1(input string name, input logic s, input logic r, input logic f);
    chk({name, " o_sw"},  {3'b0, w1_sw},   {3'b0, s});
    chk({name, " rise"},  {3'b0, w1_rise}, {3'b0, r});
    chk({name, " fall"},  {3'b0, w1_fall}, {3'b0, f});
  endtask

  initial begin
    // reset with all switches high, then release: rise on the 11th edge after release
    add(1, 4'hF, 3,  4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 10, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 1,  4'hF, 4'hF, 4'h0);
    add(0, 4'hF, 2,  4'hF, 4'h0, 4'h0);
    // release bit 3
    add(0, 4'h7, 10, 4'hF, 4'h0, 4'h0);
    add(0, 4'h7, 1,  4'h7, 4'h0, 4'h8);
    add(0, 4'h7, 2,  4'h7, 4'h0, 4'h0);
    // all low
    add(0, 4'h0, 10, 4'h7, 4'h0, 4'h0);
    add(0, 4'h0, 1,  4'h0, 4'h0, 4'h7);
    add(0, 4'h0, 2,  4'h0, 4'h0, 4'h0);
    // clean press of bit 0
    add(0, 4'h1, 10, 4'h0, 4'h0, 4'h0);
    add(0, 4'h1, 1,  4'h1, 4'h1, 4'h0);
    add(0, 4'h1, 2,  4'h1, 4'h0, 4'h0);
    // bit 1 bouncing every 3 cycles for 60 cycles, then held low
    for (int i = 0; i < 20; i++)
      add(0, (i % 2 == 0) ? 4'h3 : 4'h1, 3, 4'h1, 4'h0, 4'h0);
    add(0, 4'h1, 12, 4'h1, 4'h0, 4'h0);
    // bit 2: 7 high, 1 low glitch, then high; rise counts from the last change
    add(0, 4'h5, 7,  4'h1, 4'h0, 4'h0);
    add(0, 4'h1, 1,  4'h1, 4'h0, 4'h0);
    add(0, 4'h5, 10, 4'h1, 4'h0, 4'h0);
    add(0, 4'h5, 1,  4'h5, 4'h4, 4'h0);
    add(0, 4'h5, 2,  4'h5, 4'h0, 4'h0);
    // simultaneous: bit 1 rises, bit 0 falls
    add(0, 4'h6, 10, 4'h5, 4'h0, 4'h0);
    add(0, 4'h6, 1,  4'h6, 4'h2, 4'h1);
    add(0, 4'h6, 2,  4'h6, 4'h0, 4'h0);
    // simultaneous: bit 0 rises, bit 1 falls
    add(0, 4'h5, 10, 4'h6, 4'h0, 4'h0);
    add(0, 4'h5, 1,  4'h5, 4'h1, 4'h2);
    add(0, 4'h5, 2,  4'h5, 4'h0, 4'h0);
    // bit 3 pending, reset mid-count: all clear with no pulse, then requalify
    add(0, 4'hD, 7,  4'h5, 4'h0, 4'h0);
    add(1, 4'hD, 3,  4'h0, 4'h0, 4'h0);
    add(0, 4'hD, 10, 4'h0, 4'h0, 4'h0);
    add(0, 4'hD, 1,  4'hD, 4'hD, 4'h0);
    add(0, 4'hD, 2,  4'hD, 4'h0, 4'h0);

    for (int r = 0; r < vq.size(); r++) begin
      tb_reset = vq[r].rst;
      tb_sw    = vq[r].sw;
      for (int c = 0; c < vq[r].ncyc; c++) begin
        step();
        chk($sformatf("row%0d.c%0d o_sw", r, c),      w_sw,   vq[r].e_sw);
        chk($sformatf("row%0d.c%0d o_sw_rise", r, c), w_rise, vq[r].e_rise);
        chk($sformatf("row%0d.c%0d o_sw_fall", r, c), w_fall, vq[r].e_fall);
      end
    end

    // DEBOUNCE_LIMIT=1: four-edge latency, single-cycle pulses
    tb_reset = 1'b1;
    tb_sw1   = 1'b0;
    step(); step();
    chk1("l1 reset", 1'b0, 1'b0, 1'b0);
    tb_reset = 1'b0;
    step(); step(); step();
    chk1("l1 idle", 1'b0, 1'b0, 1'b0);
    tb_sw1 = 1'b1;
    step(); step(); step();
    chk1("l1 rise pending", 1'b0, 1'b0, 1'b0);
    step();
    chk1("l1 rise", 1'b1, 1'b1, 1'b0);
    step();
    chk1("l1 high", 1'b1, 1'b0, 1'b0);
    tb_sw1 = 1'b0;
    step(); step(); step();
    chk1("l1 fall pending", 1'b1, 1'b0, 1'b0);
    step();
    chk1("l1 fall", 1'b0, 1'b0, 1'b1);
    step();
    chk1("l1 low", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
